// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stability-qualified debouncer driving registered q/rise/fall/busy.
// Optional synchronous preset-to-1 input is compiled in when DEBOUNCE_PRESET_EN is defined.
module debounce_sync #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned STABLE_CNT = 8,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
`ifdef DEBOUNCE_PRESET_EN
  input  logic preset,
`endif
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {STABLE, PEND} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             d_s1, d_s2;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             q_nx, rise_nx, fall_nx;

  // Sync flops keep sampling through preset; only rst touches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_s1 <= RESET_VAL;
      d_s2 <= RESET_VAL;
    end else begin
      d_s1 <= d;
      d_s2 <= d_s1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
`ifdef DEBOUNCE_PRESET_EN
    if (preset) begin
      state_nx = STABLE;
      cnt_nx   = '0;
      q_nx     = 1'b1;
    end else begin
`else
    begin
`endif
      case (state)
        STABLE: begin
          if (d_s2 != q) begin
            state_nx = PEND;
            cnt_nx   = CNT_W'(1);
          end else begin
            cnt_nx   = '0;
          end
        end
        PEND: begin
          if (d_s2 == q) begin
            state_nx = STABLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = STABLE;
            cnt_nx   = '0;
            q_nx     = d_s2;
            rise_nx  = d_s2;
            fall_nx  = ~d_s2;
          end else begin
            cnt_nx   = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // busy is registered from the next state so it lines up with the state it reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
      busy  <= (state_nx == PEND);
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: two instances (RESET_VAL 0 and 1) against a run-length reference model.
module tb_debounce_sync;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  logic d;
`ifdef DEBOUNCE_PRESET_EN
  logic preset;
`endif
  logic q0, rise0, fall0, busy0;
  logic q1, rise1, fall1, busy1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state per instance: sync pipeline, run of differing edges, outputs.
  logic m_s1[2], m_s2[2], m_q[2], m_rise[2], m_fall[2], m_busy[2];
  int   m_run[2];

  debounce_sync #(.CNT_W(4), .STABLE_CNT(N), .RESET_VAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .d(d),
`ifdef DEBOUNCE_PRESET_EN
    .preset(preset),
`endif
    .q(q0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  debounce_sync #(.CNT_W(4), .STABLE_CNT(N), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .d(d),
`ifdef DEBOUNCE_PRESET_EN
    .preset(preset),
`endif
    .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b (t=%0t)", tag, obs, exp, $time);
  endtask

  // q follows the synchronised input once it has differed from q on N consecutive edges.
  task automatic model_edge(input int i, input logic dv, input logic rv, input logic pv);
    logic seen;
    if (rv) begin
      m_s1[i] = (i == 1); m_s2[i] = (i == 1); m_q[i] = (i == 1);
      m_run[i] = 0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0;
      return;
    end
    seen    = m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = dv;
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (pv) begin
      m_q[i] = 1'b1;
      m_run[i] = 0;
    end else if (seen != m_q[i]) begin
      m_run[i]++;
      if (m_run[i] == N) begin
        m_q[i]    = seen;
        m_rise[i] = seen;
        m_fall[i] = ~seen;
        m_run[i]  = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    m_busy[i] = (m_run[i] != 0);
  endtask

  task automatic tick(input logic dv, input logic rv, input logic pv);
    d   = dv;
    rst = rv;
`ifdef DEBOUNCE_PRESET_EN
    preset = pv;
`endif
    @(posedge clk);
    model_edge(0, dv, rv, pv);
    model_edge(1, dv, rv, pv);
    #1;
    chk("dut0.q",    q0,    m_q[0]);
    chk("dut0.rise", rise0, m_rise[0]);
    chk("dut0.fall", fall0, m_fall[0]);
    chk("dut0.busy", busy0, m_busy[0]);
    chk("dut1.q",    q1,    m_q[1]);
    chk("dut1.rise", rise1, m_rise[1]);
    chk("dut1.fall", fall1, m_fall[1]);
    chk("dut1.busy", busy1, m_busy[1]);
  endtask

  initial begin
    // reset with d=1, then release and let the level qualify
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    // clean level changes
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    // short pulses that must be rejected
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    // reset mid-qualification (dut0 counter at 2)
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    // toggle every cycle
    for (int k = 0; k < 40; k++) tick(((k % 2) == 1), 1'b0, 1'b0);
    // random runs with occasional reset
    for (int k = 0; k < 60; k++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(1, 0));
      len = int'($urandom_range(7, 1));
      for (int j = 0; j < len; j++) tick(v, ($urandom_range(99, 0) == 0), 1'b0);
    end
`ifdef DEBOUNCE_PRESET_EN
    tick(1'b0, 1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
